// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 keypad row scanner with column sync,
// press/release debounce, one event per press and 2-digit history.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV        = 16,
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic       int_osc,
  input  logic       reset,
  input  logic [3:0] col,
  output logic [3:0] r_sel,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DWELL_END = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_END = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    row_q, row_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    cap_q, cap_d;
  logic [3:0]    col_m_q, col_s_q;
  logic [3:0]    r_sel_q, r_sel_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_held_q, key_held_d;
  logic [3:0]    digit_new_q, digit_new_d;
  logic [3:0]    digit_old_q, digit_old_d;
  logic [3:0]    new_key;
  logic          one_hot;

  function automatic logic [3:0] encode(
    input logic [1:0] row,
    input logic [3:0] c
  );
    logic [3:0] code;
    code = 4'h0;
    case ({row, c})
      6'b00_0001: code = 4'h1;
      6'b00_0010: code = 4'h2;
      6'b00_0100: code = 4'h3;
      6'b00_1000: code = 4'hA;
      6'b01_0001: code = 4'h4;
      6'b01_0010: code = 4'h5;
      6'b01_0100: code = 4'h6;
      6'b01_1000: code = 4'hB;
      6'b10_0001: code = 4'h7;
      6'b10_0010: code = 4'h8;
      6'b10_0100: code = 4'h9;
      6'b10_1000: code = 4'hC;
      6'b11_0001: code = 4'hF;
      6'b11_0010: code = 4'h0;
      6'b11_0100: code = 4'hE;
      6'b11_1000: code = 4'hD;
      default:    code = 4'h0;
    endcase
    return code;
  endfunction

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    dwell_d     = dwell_q;
    cnt_d       = cnt_q;
    cap_d       = cap_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    digit_new_d = digit_new_q;
    digit_old_d = digit_old_q;
    new_key     = encode(row_q, cap_q);
    one_hot     = (cap_q != 4'h0) &&
                  ((cap_q & (cap_q - 4'd1)) == 4'h0);
    unique case (state_q)
      SCAN: begin
        if (dwell_q == DWELL_END) begin
          dwell_d = '0;
          if (col_s_q == 4'h0) begin
            row_d = row_q + 2'd1;
          end else begin
            cap_d   = col_s_q;
            cnt_d   = '0;
            state_d = DEBOUNCE;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (col_s_q != cap_q) begin
          state_d = SCAN;
          dwell_d = '0;
        end else if (cnt_q == CNT_END) begin
          state_d = HELD;
          // multi-key chords land in HELD silently
          if (one_hot) begin
            key_valid_d = 1'b1;
            key_code_d  = new_key;
            digit_old_d = digit_new_q;
            digit_new_d = new_key;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (col_s_q == 4'h0) begin
          cnt_d   = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (col_s_q != 4'h0) begin
          state_d = HELD;
        end else if (cnt_q == CNT_END) begin
          state_d = SCAN;
          row_d   = row_q + 2'd1;
          dwell_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = SCAN;
    endcase
    r_sel_d    = 4'b0001 << row_d;
    key_held_d = (state_d == HELD) || (state_d == RELEASE);
  end

  always_ff @(posedge int_osc or negedge reset) begin
    if (!reset) begin
      state_q     <= SCAN;
      row_q       <= 2'd0;
      dwell_q     <= '0;
      cnt_q       <= '0;
      cap_q       <= 4'h0;
      col_m_q     <= 4'h0;
      col_s_q     <= 4'h0;
      r_sel_q     <= 4'b0001;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      digit_new_q <= 4'h0;
      digit_old_q <= 4'h0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      dwell_q     <= dwell_d;
      cnt_q       <= cnt_d;
      cap_q       <= cap_d;
      col_m_q     <= col;
      col_s_q     <= col_m_q;
      r_sel_q     <= r_sel_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      digit_new_q <= digit_new_d;
      digit_old_q <= digit_old_d;
    end
  end

  assign r_sel     = r_sel_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign digit_new = digit_new_q;
  assign digit_old = digit_old_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: directed keypad scenarios with hand-timed
// expectations for SCAN_DIV=4, DEBOUNCE_CYCLES=8.
module tb_keypad_scan_ctrl;

  logic            int_osc = 1'b0;
  logic            reset;
  logic [3:0]      col;
  logic [3:0]      r_sel;
  logic [3:0]      key_code;
  logic            key_valid;
  logic            key_held;
  logic [3:0]      digit_new;
  logic [3:0]      digit_old;
  logic [3:0][3:0] key_cols;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;
  int base;

  keypad_scan_ctrl #(
    .SCAN_DIV       (4),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .int_osc  (int_osc),
    .reset    (reset),
    .col      (col),
    .r_sel    (r_sel),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held),
    .digit_new(digit_new),
    .digit_old(digit_old)
  );

  always #5 int_osc = ~int_osc;

  // a key shows on its column only while its row is driven
  always_comb begin
    col = 4'h0;
    for (int i = 0; i < 4; i++)
      if (r_sel[i]) col = col | key_cols[i];
  end

  always @(negedge int_osc)
    if (key_valid) pulses <= pulses + 1;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge int_osc);
    #1;
  endtask

  initial begin
    key_cols = '0;
    reset    = 1'b0;
    step(2);
    check("rst r_sel", r_sel, 4'b0001);
    check("rst valid", key_valid, 0);
    check("rst held", key_held, 0);
    check("rst code", key_code, 0);
    reset = 1'b1;

    // 1: idle scan
    step(3);  check("scan r0", r_sel, 4'b0001);
    step(1);  check("scan r1", r_sel, 4'b0010);
    step(4);  check("scan r2", r_sel, 4'b0100);
    step(4);  check("scan r3", r_sel, 4'b1000);
    step(4);  check("scan wrap", r_sel, 4'b0001);
    check("idle pulses", pulses, 0);
    check("idle new", digit_new, 0);
    check("idle old", digit_old, 0);

    // 2: '3' then '5'
    key_cols[0] = 4'b0100;
    step(100);
    key_cols[0] = 4'h0;
    step(20);
    check("k3 pulses", pulses, 1);
    check("k3 new", digit_new, 4'h3);
    base = pulses;
    key_cols[1] = 4'b0010;
    step(200);
    check("k5 pulses", pulses - base, 1);
    check("k5 code", key_code, 4'h5);
    check("k5 new", digit_new, 4'h5);
    check("k5 old", digit_old, 4'h3);
    check("k5 r_sel", r_sel, 4'b0010);
    check("k5 held", key_held, 1);
    key_cols[1] = 4'h0;
    step(10);
    check("k5 rel r_sel", r_sel, 4'b0010);
    check("k5 rel held", key_held, 1);
    step(1);
    check("k5 adv r_sel", r_sel, 4'b0100);
    check("k5 adv held", key_held, 0);

    // 3: bouncing '7'
    base = pulses;
    for (int k = 0; k < 14; k++) begin
      key_cols[2] = (k % 2 == 0) ? 4'b0001 : 4'b0000;
      step(3);
    end
    check("k7 bounce", pulses - base, 0);
    key_cols[2] = 4'b0001;
    step(10);
    check("k7 early", pulses - base, 0);
    step(50);
    check("k7 pulses", pulses - base, 1);
    check("k7 code", key_code, 4'h7);
    check("k7 new", digit_new, 4'h7);
    check("k7 old", digit_old, 4'h5);
    key_cols[2] = 4'h0;
    step(20);

    // 4: '1'+'2' chord
    base = pulses;
    key_cols[0] = 4'b0011;
    step(60);
    check("chord pulses", pulses - base, 0);
    check("chord held", key_held, 1);
    check("chord r_sel", r_sel, 4'b0001);
    check("chord new", digit_new, 4'h7);
    check("chord old", digit_old, 4'h5);
    key_cols[0] = 4'b0010;
    step(20);
    check("chord half", key_held, 1);
    key_cols[0] = 4'h0;
    step(10);
    check("chord rel", key_held, 1);
    step(1);
    check("chord done", key_held, 0);

    // 5: long 'D' hold with bouncy release
    base = pulses;
    key_cols[3] = 4'b1000;
    step(1000);
    check("kD pulses", pulses - base, 1);
    check("kD code", key_code, 4'hD);
    check("kD new", digit_new, 4'hD);
    check("kD old", digit_old, 4'h7);
    for (int k = 0; k < 3; k++) begin
      key_cols[3] = 4'h0;
      step(4);
      key_cols[3] = 4'b1000;
      step(2);
    end
    check("kD bounce held", key_held, 1);
    key_cols[3] = 4'h0;
    step(10);
    check("kD rel held", key_held, 1);
    check("kD rel r_sel", r_sel, 4'b1000);
    step(1);
    check("kD done held", key_held, 0);
    check("kD wrap r_sel", r_sel, 4'b0001);
    check("kD once", pulses - base, 1);

    // 6: reset while 'E' is held
    base = pulses;
    key_cols[3] = 4'b0100;
    step(60);
    check("kE pulses", pulses - base, 1);
    check("kE code", key_code, 4'hE);
    check("kE held", key_held, 1);
    reset = 1'b0;
    #2;
    check("arst r_sel", r_sel, 4'b0001);
    check("arst code", key_code, 0);
    check("arst held", key_held, 0);
    check("arst new", digit_new, 0);
    check("arst old", digit_old, 0);
    step(3);
    reset = 1'b1;
    base = pulses;
    step(1);
    check("rel r_sel", r_sel, 4'b0001);
    check("rel valid", key_valid, 0);
    step(22);
    check("kE2 early", pulses - base, 0);
    step(1);
    check("kE2 valid", key_valid, 1);
    check("kE2 code", key_code, 4'hE);
    check("kE2 new", digit_new, 4'hE);
    check("kE2 old", digit_old, 4'h0);
    step(1);
    check("kE2 pulse", key_valid, 0);
    key_cols[3] = 4'h0;
    step(20);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
- Sequencer for the 4x4 keypad matrix: drives one-hot row select, samples the column lines, debounces, and encodes the key.
- Emits exactly one key event per physical press and maintains a two-digit history (newest/previous) for the dual seven-segment display path.
- Sits between the keypad pins and the seven-segment decoder/mux, clocked from the HSOSC-derived int_osc.

Parameters:
- SCAN_DIV, 16, cycles each row is driven before its columns are sampled; must be >= 3 to cover synchronizer latency.
- DEBOUNCE_CYCLES, 65536, consecutive stable cycles required to accept a press or a release; must be >= 2.

Ports:
- int_osc  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- col  input  4  raw keypad column lines, active-high, asynchronous to int_osc
- r_sel  output  4  one-hot active-high row drive
- key_code  output  4  hex code of the last accepted key
- key_valid  output  1  one-cycle pulse when key_code is updated
- key_held  output  1  high while an accepted or ignored press is still down (HELD/RELEASE states)
- digit_new  output  4  most recent accepted key
- digit_old  output  4  key accepted before digit_new

Behaviour:
- One clock, int_osc. Reset is asynchronous and active-low. All state is reset immediately on reset low.
- Reset values: r_sel=0001, row index 0, state SCAN, both counters 0, synchronizer flops 0, key_code=0, key_valid=0, key_held=0, digit_new=0, digit_old=0.
- col passes through a 2-flop synchronizer (col_s); the FSM sees only col_s.
- r_sel = 1 << row in all states. Row changes only on the SCAN advance or on the RELEASE exit.
- Key map as row,col-bit -> code:
  - row0: 1, 2, 3, A
  - row1: 4, 5, 6, B
  - row2: 7, 8, 9, C
  - row3: F, 0, E, D
  - col bit0 is the leftmost column.
- SCAN state:
  - Dwell counter runs 0..SCAN_DIV-1.
  - At dwell==SCAN_DIV-1 with col_s==0: row advances (3 wraps to 0) and the dwell counter clears.
  - At dwell==SCAN_DIV-1 with col_s!=0: capture cap=col_s, clear the debounce counter, go to DEBOUNCE; row holds.
- DEBOUNCE state:
  - Each cycle col_s==cap increments the counter.
  - Any cycle col_s!=cap: return to SCAN at the same row, dwell counter cleared, no event.
  - When counter==DEBOUNCE_CYCLES-1 and col_s==cap: go to HELD.
  - On that same edge, if cap is one-hot: key_valid=1 for that single cycle, key_code=encoded key, digit_old<=digit_new, digit_new<=key.
  - If cap has two or more bits set: go to HELD with no event and no register update (multi-key press is ignored).
- HELD state:
  - key_held=1.
  - Stay while col_s!=0.
  - On col_s==0: clear the counter and go to RELEASE.
- RELEASE state:
  - key_held=1.
  - Each cycle col_s==0 increments the counter.
  - Any col_s!=0: return to HELD with no event.
  - At counter==DEBOUNCE_CYCLES-1 with col_s==0: row advances (with wrap), dwell counter clears, go to SCAN, key_held=0.
- A long hold produces exactly one key_valid. A second key pressed while the first is held produces no event.
- Press-to-event latency from a clean col edge, when the press aligns with the row being sampled: 2 sync cycles + up to SCAN_DIV dwell + DEBOUNCE_CYCLES.
- Counter widths are sized as clog2 of each parameter. Counters never wrap inside DEBOUNCE/RELEASE because the state exits on terminal count.
- Reset mid-operation (any state): return to the reset values above on reset assertion. No key_valid in the cycle reset deasserts. Scanning restarts at row 0.

Test Plan:
Bench parameters: SCAN_DIV=4, DEBOUNCE_CYCLES=8. The keypad model drives col = the pressed key's column bit only while r_sel matches that key's row.
1. Reset, no keys -> r_sel=0001 after reset, then 0010, 0100, 1000, 0001 every 4 cycles; key_valid never asserts; digit_new=digit_old=0.
2. Press '5' (row1, col 0010) cleanly for 200 cycles after prior key '3' -> exactly one key_valid; key_code=5, digit_new=5, digit_old=3. r_sel holds 0010 through release plus 8 stable cycles, then goes to 0100.
3. Press '7' bouncing with period 3 cycles for 40 cycles, then stable -> no pulse during bounce; one pulse with key_code=7 only after 8 stable cycles.
4. Press '1' and '2' together (row0, col 0011) -> no key_valid, digits unchanged, key_held=1 until both are released and 8 quiet cycles elapse.
5. Hold 'D' for 1000 cycles, then bounce the release 3 times -> single pulse with key_code=D; no second pulse; key_held drops only after 8 continuous quiet cycles.
6. Assert reset in HELD after pressing 'E' -> all outputs return to their reset values asynchronously. After deassert, r_sel=0001 and scanning resumes; E is still held and is accepted again once row3 is reached.
